// File: rtl/bsg_ring_node_pkg.sv
// Shared definitions for the ring endpoint: default widths and the
// classification applied to each forward-ring input packet.
package bsg_ring_node_pkg;

    localparam int RING_ID_W      = 6;
    localparam int RING_PAYLOAD_W = 16;
    localparam int RING_MAX_OUT   = 4;
    localparam int RING_DROP_W    = 16;

    // What a node does with the packet on its forward input this cycle.
    typedef enum logic [1:0] {
        FWD_IDLE,
        FWD_PASS,
        FWD_EJECT,
        FWD_DROP
    } fwd_act_e;

endpackage

// File: rtl/bsg_ring_node_if.sv
// Local client port of a ring node: injection (valid/ready) and
// ejection (valid/yumi). master = client side, slave = node side.
interface bsg_ring_node_if
    import bsg_ring_node_pkg::*;
#(
    parameter int id_width_p      = RING_ID_W,
    parameter int payload_width_p = RING_PAYLOAD_W
) ();

    logic                       inj_v_i;
    logic [id_width_p-1:0]      inj_dest_i;
    logic [payload_width_p-1:0] inj_data_i;
    logic                       inj_ready_o;
    logic                       eject_v_o;
    logic [id_width_p-1:0]      eject_src_o;
    logic [payload_width_p-1:0] eject_data_o;
    logic                       eject_yumi_i;

    modport master (
        output inj_v_i, inj_dest_i, inj_data_i, eject_yumi_i,
        input  inj_ready_o, eject_v_o, eject_src_o, eject_data_o
    );

    modport slave (
        input  inj_v_i, inj_dest_i, inj_data_i, eject_yumi_i,
        output inj_ready_o, eject_v_o, eject_src_o, eject_data_o
    );

endinterface

// File: rtl/bsg_ring_node_credit.sv
// Outstanding-injection counter: +1 on i_up, -0/1/2 on i_dn.
// Ports: clk, reset, i_up, i_dn[1:0], o_full (count == max_p).
module bsg_ring_credit_counter
    import bsg_ring_node_pkg::*;
#(
    parameter int max_p = RING_MAX_OUT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_up,
    input  logic [1:0] i_dn,
    output logic       o_full
);

    localparam int CW = $clog2(max_p + 1);

    logic [CW-1:0] r_cnt;
    logic [CW:0]   w_sum;
    logic [CW:0]   w_dn;
    logic [CW:0]   w_next;

    assign w_sum  = {1'b0, r_cnt} + (CW+1)'(i_up);
    assign w_dn   = (CW+1)'(i_dn);
    assign w_next = w_sum - w_dn;
    assign o_full = (r_cnt == CW'(max_p));

    always_ff @(posedge clk) begin
        if (reset) r_cnt <= '0;
        else       r_cnt <= w_next[CW-1:0];
    end

    // More credits returned than injections outstanding.
    a_no_underflow: assert property (
        @(posedge clk) disable iff (reset) w_sum >= w_dn
    );

endmodule

// File: rtl/bsg_ring_node.sv
// Per-tile ring endpoint: registered forward (data) and backward (ack) hops,
// eject/drop/pass classification, local injection into free slots.
// Ports: clk, reset, my_id_i, fwd_data_i/o, back_data_i/o, loc (client
// inject/eject), drop_o pulse, drop_count_o saturating counter.
module bsg_ring_node
    import bsg_ring_node_pkg::*;
#(
    parameter int  id_width_p        = RING_ID_W,
    parameter int  payload_width_p   = RING_PAYLOAD_W,
    parameter int  max_outstanding_p = RING_MAX_OUT,
    localparam int width_fwd_lp      = 1 + 2*id_width_p + payload_width_p,
    localparam int width_back_lp     = 1 + id_width_p
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [id_width_p-1:0]    my_id_i,
    input  logic [width_fwd_lp-1:0]  fwd_data_i,
    output logic [width_fwd_lp-1:0]  fwd_data_o,
    input  logic [width_back_lp-1:0] back_data_i,
    output logic [width_back_lp-1:0] back_data_o,
    bsg_ring_node_if.slave           loc,
    output logic                     drop_o,
    output logic [RING_DROP_W-1:0]   drop_count_o
);

    typedef struct packed {
        logic                       v;
        logic [id_width_p-1:0]      dest;
        logic [id_width_p-1:0]      src;
        logic [payload_width_p-1:0] payload;
    } ring_fwd_pkt_s;

    typedef struct packed {
        logic                  v;
        logic [id_width_p-1:0] dest;
    } ring_back_pkt_s;

    ring_fwd_pkt_s              w_fin, w_fout_n, r_fout;
    ring_back_pkt_s             w_bin, w_bout_n, r_bout;
    fwd_act_e                   w_act;
    logic                       r_ej_v;
    logic [id_width_p-1:0]      r_ej_src;
    logic [payload_width_p-1:0] r_ej_data;
    logic                       r_ack_v;
    logic [id_width_p-1:0]      r_ack_dest;
    logic                       r_drop;
    logic [RING_DROP_W-1:0]     r_drop_cnt;
    logic                       w_ej_free;
    logic                       w_back_fwd;
    logic                       w_back_take;
    logic                       w_ack_send;
    logic                       w_ack_free;
    logic                       w_full;
    logic                       w_inj;
    logic [1:0]                 w_credits;

    assign w_fin = fwd_data_i;
    assign w_bin = back_data_i;

    assign w_ej_free   = !r_ej_v || loc.eject_yumi_i;
    assign w_back_fwd  = w_bin.v && (w_bin.dest != my_id_i);
    assign w_back_take = w_bin.v && (w_bin.dest == my_id_i);
    // The pending ack leaves whenever the back slot is not carrying transit.
    assign w_ack_send  = r_ack_v && !w_back_fwd;
    assign w_ack_free  = !r_ack_v || w_ack_send;

    // Eject wins over drop so self-addressed packets are delivered.
    always_comb begin
        w_act = FWD_IDLE;
        if (w_fin.v) begin
            if (w_fin.dest == my_id_i && w_ej_free && w_ack_free)
                w_act = FWD_EJECT;
            else if (w_fin.src == my_id_i)
                w_act = FWD_DROP;
            else
                w_act = FWD_PASS;
        end
    end

    assign loc.inj_ready_o = (w_act != FWD_PASS) && !w_full;
    assign w_inj           = loc.inj_v_i && loc.inj_ready_o;

    always_comb begin
        w_fout_n = '0;
        if (w_inj) begin
            w_fout_n.v       = 1'b1;
            w_fout_n.dest    = loc.inj_dest_i;
            w_fout_n.src     = my_id_i;
            w_fout_n.payload = loc.inj_data_i;
        end else if (w_act == FWD_PASS) begin
            w_fout_n = w_fin;
        end
    end

    always_comb begin
        w_bout_n = '0;
        if (w_back_fwd) begin
            w_bout_n = w_bin;
        end else if (r_ack_v) begin
            w_bout_n.v    = 1'b1;
            w_bout_n.dest = r_ack_dest;
        end
    end

    assign w_credits = {1'b0, w_act == FWD_DROP} + {1'b0, w_back_take};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fout     <= '0;
            r_bout     <= '0;
            r_ej_v     <= 1'b0;
            r_ej_src   <= '0;
            r_ej_data  <= '0;
            r_ack_v    <= 1'b0;
            r_ack_dest <= '0;
            r_drop     <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            r_fout <= w_fout_n;
            r_bout <= w_bout_n;
            r_drop <= (w_act == FWD_DROP);
            if (w_act == FWD_EJECT) begin
                r_ej_v    <= 1'b1;
                r_ej_src  <= w_fin.src;
                r_ej_data <= w_fin.payload;
            end else if (loc.eject_yumi_i) begin
                r_ej_v <= 1'b0;
            end
            if (w_act == FWD_EJECT) begin
                r_ack_v    <= 1'b1;
                r_ack_dest <= w_fin.src;
            end else if (w_ack_send) begin
                r_ack_v <= 1'b0;
            end
            if (w_act == FWD_DROP && r_drop_cnt != '1)
                r_drop_cnt <= r_drop_cnt + 1'b1;
        end
    end

    bsg_ring_credit_counter #(
        .max_p (max_outstanding_p)
    ) u_cred (
        .clk    (clk),
        .reset  (reset),
        .i_up   (w_inj),
        .i_dn   (w_credits),
        .o_full (w_full)
    );

    assign fwd_data_o       = r_fout;
    assign back_data_o      = r_bout;
    assign loc.eject_v_o    = r_ej_v;
    assign loc.eject_src_o  = r_ej_src;
    assign loc.eject_data_o = r_ej_data;
    assign drop_o           = r_drop;
    assign drop_count_o     = r_drop_cnt;

endmodule

// File: tb/tb_bsg_ring_node.sv
// Four-node ring bench: directed injections with a per-node eject
// scoreboard checked by a separate monitor process.
module tb_bsg_ring_node;

    localparam int IDW = 6;
    localparam int PW  = 16;
    localparam int FW  = 1 + 2*IDW + PW;
    localparam int BW  = 1 + IDW;

    typedef struct {
        int          src;
        logic [15:0] data;
        int          cyc;
    } exp_t;

    logic          clk;
    logic          reset;
    logic [FW-1:0] fwd  [4];
    logic [BW-1:0] back [4];
    logic          inj_v [4];
    logic [IDW-1:0] inj_dest [4];
    logic [PW-1:0] inj_data [4];
    logic          inj_ready [4];
    logic          auto_y [4];
    logic          ev [4];
    logic [IDW-1:0] esrc [4];
    logic [PW-1:0] edata [4];
    logic          drop [4];
    logic [15:0]   dcnt [4];

    exp_t sb [4][$];
    int   drops_seen [4];
    int   cyc;
    int   checks;
    int   errors;

    for (genvar i = 0; i < 4; i++) begin : g
        bsg_ring_node_if #(.id_width_p(IDW), .payload_width_p(PW)) lif ();
        assign lif.inj_v_i      = inj_v[i];
        assign lif.inj_dest_i   = inj_dest[i];
        assign lif.inj_data_i   = inj_data[i];
        assign lif.eject_yumi_i = lif.eject_v_o & auto_y[i];
        assign inj_ready[i]     = lif.inj_ready_o;
        assign ev[i]            = lif.eject_v_o;
        assign esrc[i]          = lif.eject_src_o;
        assign edata[i]         = lif.eject_data_o;

        bsg_ring_node #(
            .id_width_p        (IDW),
            .payload_width_p   (PW),
            .max_outstanding_p (4)
        ) u_node (
            .clk          (clk),
            .reset        (reset),
            .my_id_i      (IDW'(i)),
            .fwd_data_i   (fwd[(i+3)%4]),
            .fwd_data_o   (fwd[i]),
            .back_data_i  (back[(i+1)%4]),
            .back_data_o  (back[i]),
            .loc          (lif),
            .drop_o       (drop[i]),
            .drop_count_o (dcnt[i])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard whenever a node hands a packet over.
    always @(negedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                if (drop[i]) drops_seen[i]++;
                if (ev[i] && auto_y[i]) begin
                    if (sb[i].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_eject node %0d: src %0d data %0h, none expected",
                                 i, esrc[i], edata[i]);
                    end else begin
                        exp_t e;
                        e = sb[i].pop_front();
                        chk($sformatf("eject_src_n%0d", i), 32'(esrc[i]), 32'(e.src));
                        chk($sformatf("eject_data_n%0d", i), 32'(edata[i]), 32'(e.data));
                        if (e.cyc >= 0)
                            chk($sformatf("eject_cycle_n%0d", i), 32'(cyc), 32'(e.cyc));
                    end
                end
            end
        end
    end

    // hops < 0: arrival time not checked; push = 0: packet is not delivered.
    task automatic inject(int n, int d, logic [15:0] data, int hops, bit push);
        int   w;
        exp_t e;
        inj_v[n]    = 1'b1;
        inj_dest[n] = IDW'(d);
        inj_data[n] = data;
        w = 0;
        #1;
        while (!inj_ready[n] && w < 40) begin
            @(negedge clk);
            #1;
            w++;
        end
        if (!inj_ready[n]) begin
            checks++;
            errors++;
            $display("FAIL inject_timeout node %0d: ready 0 expected 1", n);
            inj_v[n] = 1'b0;
            return;
        end
        if (push) begin
            e.src  = n;
            e.data = data;
            e.cyc  = (hops < 0) ? -1 : cyc + 1 + hops;
            sb[d].push_back(e);
        end
        @(posedge clk);
        #1;
        inj_v[n] = 1'b0;
    endtask

    task automatic wait_cycles(int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    logic [FW-1:0] exp_pkt;
    int            base;

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            inj_v[i]      = 1'b0;
            inj_dest[i]   = '0;
            inj_data[i]   = '0;
            auto_y[i]     = 1'b1;
            drops_seen[i] = 0;
        end
        wait_cycles(3);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("reset_fwd_n%0d", i), 32'(fwd[i]), 0);
            chk($sformatf("reset_eject_v_n%0d", i), 32'(ev[i]), 0);
        end
        chk("reset_drop_count_n0", 32'(dcnt[0]), 0);
        chk("reset_inj_ready_n0", 32'(inj_ready[0]), 1);
        @(negedge clk);
        reset = 1'b0;
        wait_cycles(2);

        // Single packet 0 -> 2, two hops.
        inject(0, 2, 16'hBEEF, 2, 1);
        wait_cycles(10);
        chk("outstanding_n0_after_ack", 32'(g[0].u_node.u_cred.r_cnt), 0);

        // Window fill with no consumer at node 2; three packets loop back.
        auto_y[2] = 1'b0;
        base = drops_seen[0];
        for (int k = 0; k < 4; k++)
            inject(0, 2, 16'h1000 + 16'(k), -1, k == 0);
        inj_v[0] = 1'b1;
        #1;
        chk("inj_ready_n0_full", 32'(inj_ready[0]), 0);
        @(negedge clk);
        inj_v[0] = 1'b0;
        wait_cycles(20);
        chk("drop_count_n0", 32'(dcnt[0]), 3);
        chk("drop_pulses_n0", 32'(drops_seen[0] - base), 3);
        chk("outstanding_n0_credits_back", 32'(g[0].u_node.u_cred.r_cnt), 0);
        auto_y[2] = 1'b1;
        wait_cycles(3);

        // Transit at node 1 blocks its injection for one cycle.
        inject(0, 3, 16'hA5A5, 3, 1);
        inj_v[1]    = 1'b1;
        inj_dest[1] = 6'd2;
        inj_data[1] = 16'h1234;
        #1;
        chk("inj_ready_n1_transit", 32'(inj_ready[1]), 0);
        @(posedge clk);
        #1;
        exp_pkt = {1'b1, 6'd3, 6'd0, 16'hA5A5};
        chk("transit_at_n2_input", 32'(fwd[1]), 32'(exp_pkt));
        inject(1, 2, 16'h1234, 1, 1);
        wait_cycles(8);

        // Self-addressed packet goes the full loop; ack does too.
        inject(3, 3, 16'h3333, 4, 1);
        wait_cycles(12);
        chk("outstanding_n3_self", 32'(g[3].u_node.u_cred.r_cnt), 0);
        for (int i = 0; i < 4; i++)
            chk($sformatf("back_idle_n%0d", i), 32'(back[i]), 0);

        // Reset with traffic in flight.
        inject(0, 1, 16'h0101, -1, 1);
        inject(1, 3, 16'h1313, -1, 1);
        inject(2, 0, 16'h2020, -1, 1);
        inject(3, 2, 16'h3232, -1, 1);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) sb[i].delete();
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rst_fwd_n%0d", i), 32'(fwd[i]), 0);
            chk($sformatf("rst_back_n%0d", i), 32'(back[i]), 0);
            chk($sformatf("rst_eject_v_n%0d", i), 32'(ev[i]), 0);
            chk($sformatf("rst_drop_n%0d", i), 32'(drop[i]), 0);
        end
        chk("rst_drop_count_n0", 32'(dcnt[0]), 0);
        chk("rst_outstanding_n0", 32'(g[0].u_node.u_cred.r_cnt), 0);
        chk("rst_outstanding_n1", 32'(g[1].u_node.u_cred.r_cnt), 0);
        reset = 1'b0;
        wait_cycles(1);
        inject(1, 3, 16'h5A5A, 2, 1);
        wait_cycles(10);

        // Drop counter saturation at node 1.
        auto_y[3] = 1'b0;
        @(negedge clk);
        force g[1].u_node.r_drop_cnt = 16'hFFFE;
        #1;
        release g[1].u_node.r_drop_cnt;
        #1;
        chk("drop_count_n1_preload", 32'(dcnt[1]), 32'hFFFE);
        base = drops_seen[1];
        for (int k = 0; k < 4; k++)
            inject(1, 3, 16'h7000 + 16'(k), -1, k == 0);
        wait_cycles(20);
        chk("drop_count_n1_sat", 32'(dcnt[1]), 32'hFFFF);
        chk("drop_pulses_n1", 32'(drops_seen[1] - base), 3);
        chk("outstanding_n1_sat", 32'(g[1].u_node.u_cred.r_cnt), 0);
        auto_y[3] = 1'b1;

        for (int w = 0; w < 50; w++) begin
            if (sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size() == 0)
                break;
            @(posedge clk);
        end
        wait_cycles(2);
        for (int i = 0; i < 4; i++) begin
            if (sb[i].size() != 0) begin
                checks++;
                errors++;
                $display("FAIL missing_eject node %0d: %0d packets never arrived, 0 required",
                         i, sb[i].size());
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
